mfsk_modulator: RTL and testbench

- Parametrised M-ary FSK modulator: accepts SYM_BITS-wide symbols over a valid/ready handshake and emits a square-wave tone whose half-period is selected per symbol.
- Each symbol lasts exactly SYM_CYCLES clk cycles.
- Tone switching is phase-continuous and happens only at symbol boundaries. The block signals idle and underrun conditions.
- Sits between the symbol source (framer/PRBS) and the line driver. It is the successor to the fixed four-tone divider-select modulator.

---
 rtl/mfsk_pkg.sv | 26 ++
 rtl/mfsk_tone_gen.sv | 49 ++++
 rtl/mfsk_modulator.sv | 139 +++++++++++++
 tb/tb_mfsk_modulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mfsk_pkg.sv
// Shared definitions for the M-ary FSK modulator.
//   state_t      : FSM encoding (IDLE, RUN)
//   MODE_EXP/LIN : tone law selectors carried on the mode input
//   half_period  : half-period in clk cycles for a given law and symbol
package mfsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_EXP = 1'b0;
    localparam logic MODE_LIN = 1'b1;

    // Computed at full 32-bit width so the caller can detect a result that
    // does not fit its half-period counter.
    function automatic int unsigned half_period(input logic        mode,
                                                input int unsigned sym,
                                                input int unsigned base_half);
        if (mode == MODE_LIN) begin
            return base_half * (sym + 1);
        end
        return base_half << sym;
    endfunction

endpackage

// File: rtl/mfsk_tone_gen.sv
// Half-period counter and square-wave output stage.
//   clk, reset  : clock, asynchronous active-low reset
//   en          : advance the counter (high while a symbol is on air)
//   load        : a new symbol starts on this edge; counter restarts at 0
//   force_zero  : drive tone low and clear the counter (end of transmission)
//   half        : half-period of the symbol currently on air
//   tone        : modulated square wave
module mfsk_tone_gen
    import mfsk_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             force_zero,
    input  logic [DIV_W-1:0] half,
    output logic             tone
);

    logic [DIV_W-1:0] r_hcnt;
    logic             r_tone;
    logic             w_wrap;

    // Wrap is judged against the half of the outgoing symbol, so a toggle
    // due on a boundary edge still happens: this keeps the phase continuous.
    assign w_wrap = (r_hcnt == half - DIV_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcnt <= '0;
            r_tone <= 1'b0;
        end else if (force_zero) begin
            r_hcnt <= '0;
            r_tone <= 1'b0;
        end else if (en) begin
            if (w_wrap) begin
                r_tone <= ~r_tone;
            end
            r_hcnt <= (load || w_wrap) ? '0 : r_hcnt + DIV_W'(1);
        end else if (load) begin
            r_hcnt <= '0;
        end
    end

    assign tone = r_tone;

endmodule

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: accepts SYM_BITS-wide symbols on a valid/ready
// handshake and transmits each for SYM_CYCLES clocks as a square wave whose
// half-period depends on the symbol and the selected tone law.
//   clk, reset : clock, asynchronous active-low reset
//   mode       : tone law sampled at acceptance (0 exponential, 1 linear)
//   sym_data   : symbol to transmit, sampled at acceptance
//   sym_valid  : symbol offered
//   sym_ready  : symbol taken when sym_valid & sym_ready at a rising edge
//   out        : modulated tone
//   active     : a symbol is on air
//   cur_sym    : symbol on air, 0 when idle
//   underrun   : one-cycle pulse when a symbol ends with no successor
module mfsk_modulator
    import mfsk_pkg::*;
#(
    parameter int unsigned SYM_BITS   = 2,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned BASE_HALF  = 1,
    parameter int unsigned SYM_CYCLES = 16,
    parameter int unsigned SCNT_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [SYM_BITS-1:0] sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic                out,
    output logic                active,
    output logic [SYM_BITS-1:0] cur_sym,
    output logic                underrun
);

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SYM_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [SCNT_W-1:0]   r_scnt;
    logic [SCNT_W-1:0]   w_scnt_next;
    logic [SYM_BITS-1:0] r_cur_sym;
    logic [SYM_BITS-1:0] w_cur_sym_next;
    logic [DIV_W-1:0]    r_half;
    logic [DIV_W-1:0]    w_half_next;
    logic                r_underrun;
    logic                w_underrun_next;
    logic                w_force_zero;
    logic                w_boundary;
    logic                w_accept;
    int unsigned         w_half_full;
    logic [DIV_W-1:0]    w_half_sel;
    logic                w_tone;

    assign w_half_full = half_period(mode, 32'(sym_data), BASE_HALF);
    assign w_half_sel  = w_half_full[DIV_W-1:0];
    assign w_accept    = sym_valid & sym_ready;

    always_comb begin
        w_state_next    = r_state;
        w_scnt_next     = r_scnt;
        w_cur_sym_next  = r_cur_sym;
        w_half_next     = r_half;
        w_underrun_next = 1'b0;
        w_force_zero    = 1'b0;
        w_boundary      = 1'b0;
        sym_ready       = 1'b0;
        case (r_state)
            IDLE: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    w_state_next   = RUN;
                    w_cur_sym_next = sym_data;
                    w_half_next    = w_half_sel;
                    w_scnt_next    = '0;
                end
            end
            RUN: begin
                w_boundary = (r_scnt == SCNT_LAST);
                sym_ready  = w_boundary;
                if (w_boundary) begin
                    w_scnt_next = '0;
                    if (sym_valid) begin
                        w_cur_sym_next = sym_data;
                        w_half_next    = w_half_sel;
                    end else begin
                        w_state_next    = IDLE;
                        w_cur_sym_next  = '0;
                        w_underrun_next = 1'b1;
                        w_force_zero    = 1'b1;
                    end
                end else begin
                    w_scnt_next = r_scnt + SCNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_scnt     <= '0;
            r_cur_sym  <= '0;
            r_half     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_scnt     <= w_scnt_next;
            r_cur_sym  <= w_cur_sym_next;
            r_half     <= w_half_next;
            r_underrun <= w_underrun_next;
        end
    end

    // A half-period of zero or one that does not fit DIV_W bits is a
    // parameter/mode combination this instance cannot produce.
    always @(posedge clk) begin
        if (reset && w_accept) begin
            assert (w_half_full != 0 && w_half_full <= ((64'd1 << DIV_W) - 64'd1));
        end
    end

    mfsk_tone_gen #(
        .DIV_W(DIV_W)
    ) u_tone (
        .clk       (clk),
        .reset     (reset),
        .en        (r_state == RUN),
        .load      (w_accept),
        .force_zero(w_force_zero),
        .half      (r_half),
        .tone      (w_tone)
    );

    assign out      = w_tone;
    assign active   = (r_state == RUN);
    assign cur_sym  = r_cur_sym;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_mfsk_modulator.sv
module tb_mfsk_modulator;

    typedef struct {
        bit mode;
        int sym;
        int half;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [1:0] sym_data;
    logic       valid;
    int         sel;

    logic [2:0] out_v, rdy_v, act_v, und_v;
    logic [1:0] cs0, cs1, cs2;
    logic       w_out, w_rdy, w_act, w_und;
    logic [1:0] w_cs;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl [10];
    vec_t sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: 6-cycle symbols. Instance 2: BASE_HALF=2.
    mfsk_modulator dut0 (
        .clk(clk), .reset(reset), .mode(mode), .sym_data(sym_data),
        .sym_valid(valid && sel == 0), .sym_ready(rdy_v[0]), .out(out_v[0]),
        .active(act_v[0]), .cur_sym(cs0), .underrun(und_v[0]));

    mfsk_modulator #(.SYM_CYCLES(6), .SCNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .sym_data(sym_data),
        .sym_valid(valid && sel == 1), .sym_ready(rdy_v[1]), .out(out_v[1]),
        .active(act_v[1]), .cur_sym(cs1), .underrun(und_v[1]));

    mfsk_modulator #(.BASE_HALF(2)) dut2 (
        .clk(clk), .reset(reset), .mode(mode), .sym_data(sym_data),
        .sym_valid(valid && sel == 2), .sym_ready(rdy_v[2]), .out(out_v[2]),
        .active(act_v[2]), .cur_sym(cs2), .underrun(und_v[2]));

    assign w_out = out_v[sel];
    assign w_rdy = rdy_v[sel];
    assign w_act = act_v[sel];
    assign w_und = und_v[sel];
    assign w_cs  = (sel == 0) ? cs0 : (sel == 1) ? cs1 : cs2;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    // Streams tbl[first .. first+n-1] back-to-back into the selected DUT,
    // then lets valid drop. Expected tone: within a symbol that started on
    // edge s with half h, out flips on edges s+k*h (k>=1, up to s+sc); the
    // final boundary with no successor forces out low instead.
    // Must be called at a negedge with the selected DUT idle.
    task automatic run_stream(input int first, input int n, input int sc, input bit wiggle);
        vec_t cur, rec;
        int   idx, pos, win_tog, tail, budget;
        bit   running, lvl, exp_under, boundary, acc, prev_out, done;
        idx = 0; pos = 0; win_tog = 0; tail = 0; done = 0;
        running = 0; lvl = 0; exp_under = 0;
        cur = tbl[first];
        sb_q.delete();
        prev_out = w_out;
        mode     = tbl[first].mode;
        sym_data = 2'(tbl[first].sym);
        valid    = (n > 0);
        budget   = n * sc + 10;
        for (int c = 0; c < budget; c++) begin
            check("sym_ready", w_rdy, int'(!running || pos == sc - 1));
            boundary = running && (pos == sc - 1);
            acc      = valid && (!running || boundary);
            if (acc) sb_q.push_back(tbl[first + idx]);
            @(posedge clk);
            if (running) begin
                if (boundary && !valid) begin
                    lvl = 0; running = 0; exp_under = 1;
                end else begin
                    exp_under = 0;
                    if (((pos + 1) % cur.half) == 0) lvl = ~lvl;
                end
                if (boundary) begin
                    rec = sb_q.pop_front();
                    check("win_toggles", win_tog, (sc - 1) / rec.half);
                    $display("xact sel=%0d sym=%0d mode=%0d half=%0d toggles=%0d",
                             sel, rec.sym, rec.mode, rec.half, win_tog);
                    win_tog = 0; pos = 0;
                    if (valid) cur = sb_q[0];
                end else begin
                    pos++;
                end
            end else begin
                exp_under = 0;
                if (acc) begin
                    running = 1; pos = 0; win_tog = 0; cur = sb_q[0];
                end
            end
            if (acc) idx++;
            @(negedge clk);
            if (running && pos != 0 && w_out != prev_out) win_tog++;
            prev_out = w_out;
            check("out", w_out, lvl);
            check("active", w_act, running);
            check("cur_sym", w_cs, running ? cur.sym : 0);
            check("underrun", w_und, exp_under);
            if (idx >= n) begin
                valid = 0;
            end else begin
                mode     = tbl[first + idx].mode;
                sym_data = 2'(tbl[first + idx].sym);
            end
            if (wiggle && running && pos != sc - 1) begin
                mode     = 1'($urandom);
                sym_data = 2'($urandom);
            end
            if (idx >= n && !running) begin
                tail++;
                if (tail == 3) begin
                    done = 1;
                    break;
                end
            end
        end
        check("stream_done", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 0, 1};
        tbl[1] = '{1'b0, 1, 2};
        tbl[2] = '{1'b0, 2, 4};
        tbl[3] = '{1'b0, 3, 8};
        tbl[4] = '{1'b0, 2, 4};
        tbl[5] = '{1'b0, 0, 1};
        tbl[6] = '{1'b1, 3, 8};
        tbl[7] = '{1'b1, 0, 2};
        tbl[8] = '{1'b1, 1, 4};
        tbl[9] = '{1'b0, 1, 2};

        sel = 0; mode = 0; sym_data = 0; valid = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #0;
            check("rst_out", w_out, 0);
            check("rst_active", w_act, 0);
            check("rst_cur_sym", w_cs, 0);
            check("rst_underrun", w_und, 0);
        end
        sel = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("idle_out", w_out, 0);
            check("idle_active", w_act, 0);
            check("idle_ready", w_rdy, 1);
            check("idle_underrun", w_und, 0);
        end

        // Exponential tones 2/4/8/16 back-to-back, ending in underrun.
        sel = 0; run_stream(0, 4, 16, 1'b0);
        // Phase continuity across a 6-cycle boundary.
        sel = 1; run_stream(4, 2, 6, 1'b0);
        // Linear law with BASE_HALF=2; mode/data wiggle mid-symbol.
        sel = 2; run_stream(6, 3, 16, 1'b1);
        // Single symbol followed by underrun.
        sel = 0; run_stream(9, 1, 16, 1'b0);

        // Reset in the middle of a symbol.
        sel = 0; mode = 0; sym_data = 2'd2; valid = 1;
        @(posedge clk);
        @(negedge clk);
        valid = 0;
        repeat (6) @(negedge clk);
        check("pre_rst_out", w_out, 1);
        check("pre_rst_active", w_act, 1);
        check("pre_rst_cur_sym", w_cs, 2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", w_out, 0);
        check("async_rst_active", w_act, 0);
        check("async_rst_cur_sym", w_cs, 0);
        check("async_rst_underrun", w_und, 0);
        repeat (2) begin
            @(negedge clk);
            check("in_rst_underrun", w_und, 0);
            check("in_rst_ready", w_rdy, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_underrun", w_und, 0);
        run_stream(9, 1, 16, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
